// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_BITS payload (LSB first),
// optional odd/even parity bit, and one or two stop bits. Each bit is held
// for CLKS_PER_BIT clock cycles. The payload is accepted through a
// valid/ready handshake that is only open while the line is idle.
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] in_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 done,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit;
    logic                 done_r;
    logic                 bit_end;

    // Last clock cycle of the bit currently on the line.
    assign bit_end = (bit_cnt == CNT_MAX);

    // State register; reset abandons any frame in flight.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: each state lasts until its bit (or bit group) ends.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (tx_valid) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bit_idx == DATA_LAST)) begin
                    state_nxt = (PARITY != 0) ? PAR : STOP;
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end && (bit_idx == STOP_LAST)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bit timing, payload shifter, parity capture and the done pulse.
    // The payload and its parity are captured at acceptance so later
    // changes on in_data cannot affect the frame.
    always_ff @(posedge CLK) begin
        if (reset) begin
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= (state == STOP) && bit_end && (bit_idx == STOP_LAST);
            if (state == IDLE) begin
                bit_cnt <= '0;
                bit_idx <= '0;
                if (tx_valid) begin
                    shift_reg <= in_data;
                    par_bit   <= (PARITY == 1) ? ~(^in_data) : (^in_data);
                end
            end else if (bit_end) begin
                bit_cnt <= '0;
                case (state)
                    DATA: begin
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= (bit_idx == DATA_LAST) ? '0 : bit_idx + 1'b1;
                    end
                    STOP: begin
                        bit_idx <= (bit_idx == STOP_LAST) ? '0 : bit_idx + 1'b1;
                    end
                    default: begin
                    end
                endcase
            end else begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    // Outputs decoded from the current state; the line idles high.
    always_comb begin
        tx_ready  = (state == IDLE);
        busy      = (state != IDLE);
        done      = done_r;
        tx_serial = 1'b1;
        case (state)
            START:   tx_serial = 1'b0;
            DATA:    tx_serial = shift_reg[0];
            PAR:     tx_serial = par_bit;
            default: tx_serial = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five instances cover the parameter variants
// (8N1, 8E1, 8O1, 8N2 at 4 clocks/bit, and 5N1 at 2 clocks/bit).
module tb_uart_tx_param;

    logic       clk;
    logic       reset;
    logic [4:0] valid;
    logic [8:0] din [5];
    wire  [4:0] ser;
    wire  [4:0] rdy;
    wire  [4:0] dn;
    wire  [4:0] bsy;

    int checks;
    int errors;

    // Instance 0: 8N1, 4 clocks per bit.
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .CLK(clk), .reset(reset), .in_data(din[0][7:0]), .tx_valid(valid[0]),
        .tx_ready(rdy[0]), .tx_serial(ser[0]), .done(dn[0]), .busy(bsy[0])
    );

    // Instance 1: 8E1.
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .CLK(clk), .reset(reset), .in_data(din[1][7:0]), .tx_valid(valid[1]),
        .tx_ready(rdy[1]), .tx_serial(ser[1]), .done(dn[1]), .busy(bsy[1])
    );

    // Instance 2: 8O1.
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .CLK(clk), .reset(reset), .in_data(din[2][7:0]), .tx_valid(valid[2]),
        .tx_ready(rdy[2]), .tx_serial(ser[2]), .done(dn[2]), .busy(bsy[2])
    );

    // Instance 3: 8N2.
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
        .CLK(clk), .reset(reset), .in_data(din[3][7:0]), .tx_valid(valid[3]),
        .tx_ready(rdy[3]), .tx_serial(ser[3]), .done(dn[3]), .busy(bsy[3])
    );

    // Instance 4: 5N1, 2 clocks per bit.
    uart_tx_param #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1)) u_5n1 (
        .CLK(clk), .reset(reset), .in_data(din[4][4:0]), .tx_valid(valid[4]),
        .tx_ready(rdy[4]), .tx_serial(ser[4]), .done(dn[4]), .busy(bsy[4])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Offers one payload on instance k and checks the line cycle by cycle
    // against exp_bits (bit 0 = first bit on the line). Called #1 after an
    // edge; returns #1 after the edge that opens the done cycle.
    // chain keeps tx_valid high with next_data for a back-to-back frame;
    // disturb toggles in_data/tx_valid during the frame.
    task automatic send_frame(input int k, input logic [8:0] data, input logic [15:0] exp_bits,
                              input int nbits, input int cpb, input bit chain,
                              input logic [8:0] next_data, input bit disturb, input string tag);
        din[k]   = data;
        valid[k] = 1'b1;
        check({tag, "_ready"}, rdy[k], 1'b1);
        @(posedge clk); #1;
        valid[k] = chain;
        if (chain) din[k] = next_data;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < cpb; c++) begin
                if (disturb) begin
                    if (b < nbits - 1) begin
                        valid[k] = 1'($urandom_range(0, 1));
                        din[k]   = 9'($urandom);
                    end else begin
                        valid[k] = 1'b0;
                    end
                end
                check({tag, "_bit"}, ser[k], exp_bits[b]);
                check({tag, "_nodone"}, dn[k], 1'b0);
                if (c == 0) begin
                    check({tag, "_busy"}, bsy[k], 1'b1);
                    check({tag, "_notready"}, rdy[k], 1'b0);
                end
                @(posedge clk); #1;
            end
        end
        check({tag, "_done"}, dn[k], 1'b1);
        check({tag, "_done_ready"}, rdy[k], 1'b1);
        check({tag, "_done_idle"}, bsy[k], 1'b0);
        check({tag, "_done_line"}, ser[k], 1'b1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int k = 0; k < 5; k++) din[k] = 9'h000;
        // Reset with a payload offered at the same time: reset must win.
        reset = 1'b1;
        valid = 5'b00001;
        din[0] = 9'h0FF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            check("rst_line", ser[k], 1'b1);
            check("rst_ready", rdy[k], 1'b1);
            check("rst_busy", bsy[k], 1'b0);
            check("rst_done", dn[k], 1'b0);
        end
        reset = 1'b0;
        valid = 5'b00000;
        @(posedge clk); #1;
        check("idle_line", ser[0], 1'b1);
        check("idle_busy", bsy[0], 1'b0);

        // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
        send_frame(0, 9'h0A5, 16'b0000001101001010, 10, 4, 1'b0, 9'h000, 1'b0, "a5");
        @(posedge clk); #1;
        check("a5_pulse_end", dn[0], 1'b0);

        // 8E1 0x07: parity 1
        send_frame(1, 9'h007, 16'b0000011000001110, 11, 4, 1'b0, 9'h000, 1'b0, "even07");
        // 8O1 0x07: parity 0
        send_frame(2, 9'h007, 16'b0000010000001110, 11, 4, 1'b0, 9'h000, 1'b0, "odd07");

        // 8N2 back-to-back with tx_valid held: 0x00 then 0xFF
        send_frame(3, 9'h000, 16'b0000011000000000, 11, 4, 1'b1, 9'h0FF, 1'b0, "s2_00");
        send_frame(3, 9'h0FF, 16'b0000011111111110, 11, 4, 1'b0, 9'h000, 1'b0, "s2_ff");
        @(posedge clk); #1;
        check("s2_pulse_end", dn[3], 1'b0);
        check("s2_no_extra", bsy[3], 1'b0);

        // 5N1 at 2 clocks/bit, 0x1F
        send_frame(4, 9'h01F, 16'b0000000001111110, 7, 2, 1'b0, 9'h000, 1'b0, "d5");
        @(posedge clk); #1;

        // Reset during data bit 3 of 0xF7 (bit 3 is 0)
        din[0]   = 9'h0F7;
        valid[0] = 1'b1;
        @(posedge clk); #1;
        valid[0] = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        check("mid_bit3", ser[0], 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_rst_line", ser[0], 1'b1);
        check("mid_rst_ready", rdy[0], 1'b1);
        check("mid_rst_done", dn[0], 1'b0);
        @(posedge clk); #1;
        check("mid_rst_nodone", dn[0], 1'b0);
        check("mid_rst_line2", ser[0], 1'b1);
        send_frame(0, 9'h03C, 16'b0000001001111000, 10, 4, 1'b0, 9'h000, 1'b0, "3c");
        @(posedge clk); #1;

        // 0x5A with in_data/tx_valid disturbed mid-frame
        send_frame(0, 9'h05A, 16'b0000001010110100, 10, 4, 1'b0, 9'h000, 1'b1, "5a");
        valid[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("5a_no_extra_ready", rdy[0], 1'b1);
            check("5a_no_extra_line", ser[0], 1'b1);
            check("5a_no_extra_done", dn[0], 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of CLK.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 434, giving CLK cycles per serial bit (50 MHz / 115200); legal range >= 2.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, giving payload bits per frame; legal range 5..9.
REQ-004 The block SHALL have parameter PARITY, default 0, selecting the parity mode: 0 none, 1 odd, 2 even.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, giving stop bits per frame; legal values 1 or 2.
REQ-006 The block SHALL have port CLK, input, width 1: system clock.
REQ-007 The block SHALL have port reset, input, width 1: synchronous active-high reset.
REQ-008 The block SHALL have port in_data, input, width DATA_BITS: payload to transmit.
REQ-009 The block SHALL have port tx_valid, input, width 1: a payload is offered on in_data.
REQ-010 The block SHALL have port tx_ready, output, width 1: the block accepts a payload this cycle.
REQ-011 The block SHALL have port tx_serial, output, width 1: serial line, idle high.
REQ-012 The block SHALL have port done, output, width 1: one-cycle pulse at frame completion.
REQ-013 The block SHALL have port busy, output, width 1: a frame is in progress.

Function
REQ-014 Frame length N SHALL be 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bits, and each bit SHALL be driven for exactly CLKS_PER_BIT cycles.
REQ-015 The FSM SHALL use states IDLE, START, DATA, PAR and STOP, with transitions IDLE->START->DATA->(PAR if PARITY != 0)->STOP->IDLE.
REQ-016 tx_ready SHALL be 1 only in IDLE, and busy SHALL equal the inverse of tx_ready.
REQ-017 Acceptance SHALL occur on the cycle with tx_valid=1 and tx_ready=1; in_data SHALL be latched on that edge, and later changes to in_data SHALL be ignored.
REQ-018 tx_valid asserted while busy SHALL have no effect, with no queueing.
REQ-019 If acceptance occurs at cycle t, the start bit (0) SHALL be driven on cycles t+1 .. t+CLKS_PER_BIT.
REQ-020 Data bits SHALL be sent LSB first, with bit i occupying cycles t+1+(1+i)*CLKS_PER_BIT .. t+(2+i)*CLKS_PER_BIT.
REQ-021 The parity bit SHALL be the XOR of the latched data for even parity and its inverse for odd parity.
REQ-022 Each stop bit SHALL drive 1, and multiple stop bits SHALL be contiguous.
REQ-023 At cycle t+N*CLKS_PER_BIT+1 the block SHALL be in IDLE with done=1 for exactly that one cycle, tx_ready=1 and tx_serial=1.
REQ-024 A new acceptance is allowed in the same cycle as done, so back-to-back frames SHALL be separated by exactly one idle-high cycle.
REQ-025 The per-bit counter SHALL be $clog2(CLKS_PER_BIT) bits wide, count 0..CLKS_PER_BIT-1 and wrap to 0 on each bit advance.
REQ-026 The bit index SHALL be $clog2(DATA_BITS+1) bits wide and SHALL never exceed DATA_BITS-1 while sampling data.
REQ-027 In IDLE, tx_serial SHALL be 1 and the counters SHALL be held at 0.

Reset
REQ-028 When reset=1 at a CLK edge, the block SHALL enter IDLE and set tx_serial=1, tx_ready=1, busy=0, done=0 and all counters and the data register to 0.
REQ-029 A reset mid-frame SHALL abandon the frame: the line returns high on the next edge and no done pulse is produced.
REQ-030 Reset SHALL take priority over acceptance in the same cycle.

Verification
REQ-031 With CLKS_PER_BIT=4, DATA_BITS=8, PARITY=0, STOP_BITS=1, sending 0xA5 SHALL produce line bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, with done at accept+41.
REQ-032 With PARITY=2, sending 0x07 SHALL produce parity bit 1; with PARITY=1, the same payload SHALL produce parity bit 0; frame length SHALL be 11 bits (44 cycles).
REQ-033 With STOP_BITS=2 and tx_valid held high, 0x00 then 0xFF SHALL give first done at t+45, second accept at t+45, second start bit at t+46, and 8 high cycles of stop.
REQ-034 A reset asserted during data bit 3 SHALL give tx_serial=1, tx_ready=1 and no done pulse on the next cycle, and the next frame (0x3C) SHALL be bit-exact.
REQ-035 Toggling in_data and pulsing tx_valid mid-frame SHALL leave the transmitted payload equal to the latched value, with no extra frame.
REQ-036 With CLKS_PER_BIT=2 and DATA_BITS=5, sending 0x1F SHALL produce 7 bits, each held 2 cycles, with done at accept+15.
